// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: grant encoding and the
// starvation-counter width helper.
package dmem_arb_pkg;

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_CORE = 2'd1;
    localparam logic [1:0] GNT_LDR  = 2'd2;

    // Bits needed to count 0..limit, never less than one.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/dmem_starve_counter.sv
// Saturating counter of consecutive loader-denied cycles; clear wins over
// increment.
module dmem_starve_counter
    import dmem_arb_pkg::*;
#(
    parameter int LIMIT = 4,
    parameter int W     = cnt_width(LIMIT)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         at_limit
);

    localparam logic [W-1:0] LIM = W'(LIMIT);

    assign at_limit = (count == LIM);

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            count <= '0;
        end else if (inc && !at_limit) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the MEM stage and the loader;
// the core has priority, the starvation counter forces loader slots.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_mem_read_i,
    input  logic                  core_mem_write_i,
    input  logic [DATA_WIDTH-1:0] core_addr_i,
    input  logic [DATA_WIDTH-1:0] core_wdata_i,
    output logic [DATA_WIDTH-1:0] core_rdata_o,
    output logic                  core_stall_o,
    input  logic                  ldr_req_i,
    input  logic                  ldr_we_i,
    input  logic [DATA_WIDTH-1:0] ldr_addr_i,
    input  logic [DATA_WIDTH-1:0] ldr_wdata_i,
    output logic                  ldr_gnt_o,
    output logic                  ldr_rvalid_o,
    output logic [DATA_WIDTH-1:0] ldr_rdata_o,
    output logic                  mem_write_o,
    output logic                  mem_read_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int CNT_W = cnt_width(STARVE_LIMIT);

    logic                  core_req;
    logic                  ldr_win;
    logic                  at_limit;
    logic [CNT_W-1:0]      starve_cnt;
    logic [1:0]            gnt;
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] rdata_p1;

    assign core_req = core_mem_read_i | core_mem_write_i;
    assign ldr_win  = ldr_req_i & (~core_req | at_limit);

    dmem_starve_counter #(
        .LIMIT (STARVE_LIMIT),
        .W     (CNT_W)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .clr      (~ldr_req_i | ldr_gnt_o),
        .inc      (ldr_req_i),
        .count    (starve_cnt),
        .at_limit (at_limit)
    );

    // Nothing is granted while reset is held, so no memory access can leak out.
    always_comb begin
        gnt = GNT_NONE;
        if (reset) begin
            if (ldr_win) begin
                gnt = GNT_LDR;
            end else if (core_req) begin
                gnt = GNT_CORE;
            end
        end
    end

    always_comb begin
        mem_addr_o  = core_addr_i;
        mem_wdata_o = core_wdata_i;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        if (gnt == GNT_LDR) begin
            mem_addr_o  = ldr_addr_i;
            mem_wdata_o = ldr_wdata_i;
            mem_read_o  = ~ldr_we_i;
            mem_write_o = ldr_we_i;
        end else if (gnt == GNT_CORE) begin
            mem_read_o  = core_mem_read_i;
            mem_write_o = core_mem_write_i;
        end
    end

    assign ldr_gnt_o    = (gnt == GNT_LDR);
    assign core_stall_o = core_req & ldr_gnt_o;
    assign core_rdata_o = ((gnt == GNT_CORE) && core_mem_read_i) ? mem_rdata_i : '0;

    // ---- stage p1: loader read data captured at the end of its grant cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p1   <= 1'b0;
            rdata_p1 <= '0;
        end else begin
            vld_p1 <= ldr_gnt_o & ~ldr_we_i;
            if (ldr_gnt_o && !ldr_we_i) begin
                rdata_p1 <= mem_rdata_i;
            end
        end
    end

    // Gating with reset drops a pulse that was already pending when reset hits.
    assign ldr_rvalid_o = vld_p1 & reset;
    assign ldr_rdata_o  = rdata_p1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: one instance at STARVE_LIMIT=4 with a memory model,
// one at STARVE_LIMIT=0; loader reads are scored through an expected-data queue.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_rd, core_wr, ldr_req, ldr_we;
    logic [31:0] core_addr, core_wdata, ldr_addr, ldr_wdata;

    logic [31:0] core_rdata, ldr_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        core_stall, ldr_gnt, ldr_rvalid, mem_write, mem_read;

    logic [31:0] core_rdata0, ldr_rdata0, mem_addr0, mem_wdata0;
    logic [31:0] mem_rdata0 = 32'hC0FFEE00;
    logic        core_stall0, ldr_gnt0, ldr_rvalid0, mem_write0, mem_read0;

    logic [31:0] mem [0:63];
    logic [5:0]  mem_idx;
    logic [31:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign mem_idx   = 6'((mem_addr >> 2) % 64);
    assign mem_rdata = mem[mem_idx];
    always @(posedge clk) if (mem_write) mem[mem_idx] <= mem_wdata;

    dmem_arbiter #(.DATA_WIDTH(32), .STARVE_LIMIT(4)) u_dut (
        .clk(clk), .reset(reset),
        .core_mem_read_i(core_rd), .core_mem_write_i(core_wr),
        .core_addr_i(core_addr), .core_wdata_i(core_wdata),
        .core_rdata_o(core_rdata), .core_stall_o(core_stall),
        .ldr_req_i(ldr_req), .ldr_we_i(ldr_we), .ldr_addr_i(ldr_addr),
        .ldr_wdata_i(ldr_wdata), .ldr_gnt_o(ldr_gnt), .ldr_rvalid_o(ldr_rvalid),
        .ldr_rdata_o(ldr_rdata), .mem_write_o(mem_write), .mem_read_o(mem_read),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    dmem_arbiter #(.DATA_WIDTH(32), .STARVE_LIMIT(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .core_mem_read_i(core_rd), .core_mem_write_i(core_wr),
        .core_addr_i(core_addr), .core_wdata_i(core_wdata),
        .core_rdata_o(core_rdata0), .core_stall_o(core_stall0),
        .ldr_req_i(ldr_req), .ldr_we_i(ldr_we), .ldr_addr_i(ldr_addr),
        .ldr_wdata_i(ldr_wdata), .ldr_gnt_o(ldr_gnt0), .ldr_rvalid_o(ldr_rvalid0),
        .ldr_rdata_o(ldr_rdata0), .mem_write_o(mem_write0), .mem_read_o(mem_read0),
        .mem_addr_o(mem_addr0), .mem_wdata_o(mem_wdata0), .mem_rdata_i(mem_rdata0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Scoreboard: every rvalid pulse consumes one expected read word.
    always @(negedge clk) begin
        if (reset === 1'b1 && ldr_rvalid === 1'b1) begin
            if (exp_q.size() == 0) chk("rvalid_unexpected", 32'd1, 32'd0);
            else chk("ldr_rdata", ldr_rdata, exp_q.pop_front());
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4] = 32'hDEADBEEF;
        reset = 1'b0;
        core_rd = 0; core_wr = 0; core_addr = 0; core_wdata = 0;
        ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;

        // Reset: requests present but nothing granted
        next_cycle();
        core_rd = 1; core_addr = 32'h10; ldr_req = 1; ldr_addr = 32'h40;
        settle();
        chk("rst_ldr_gnt", 32'(ldr_gnt), 0);
        chk("rst_stall", 32'(core_stall), 0);
        chk("rst_mem_read", 32'(mem_read), 0);
        chk("rst_mem_write", 32'(mem_write), 0);
        chk("rst_core_rdata", core_rdata, 0);
        next_cycle();
        settle();
        chk("rst_rvalid", 32'(ldr_rvalid), 0);
        chk("rst_rdata", ldr_rdata, 0);

        // Core only
        next_cycle();
        reset = 1; ldr_req = 0;
        settle();
        chk("core_rdata", core_rdata, 32'hDEADBEEF);
        chk("core_stall", 32'(core_stall), 0);
        chk("core_ldr_gnt", 32'(ldr_gnt), 0);
        chk("core_mem_read", 32'(mem_read), 1);

        // Loader write then read
        next_cycle();
        core_rd = 0; ldr_req = 1; ldr_we = 1; ldr_addr = 32'h40; ldr_wdata = 32'h12345678;
        settle();
        chk("lw_gnt", 32'(ldr_gnt), 1);
        chk("lw_mem_write", 32'(mem_write), 1);
        chk("lw_mem_addr", mem_addr, 32'h40);
        next_cycle();
        ldr_we = 0;
        exp_q.push_back(32'h12345678);
        settle();
        chk("lr_gnt", 32'(ldr_gnt), 1);
        chk("lw_no_rvalid", 32'(ldr_rvalid), 0);
        chk("lr_mem_read", 32'(mem_read), 1);
        next_cycle();
        ldr_req = 0;
        settle();
        chk("lr_rvalid", 32'(ldr_rvalid), 1);
        next_cycle();
        settle();
        chk("lr_rvalid_end", 32'(ldr_rvalid), 0);
        chk("lr_rdata_hold", ldr_rdata, 32'h12345678);

        // Back-to-back loader reads
        next_cycle();
        ldr_req = 1; ldr_addr = 32'h40;
        exp_q.push_back(32'h12345678);
        settle();
        chk("b2b_gnt0", 32'(ldr_gnt), 1);
        next_cycle();
        ldr_addr = 32'h10;
        exp_q.push_back(32'hDEADBEEF);
        settle();
        chk("b2b_gnt1", 32'(ldr_gnt), 1);
        chk("b2b_rvalid0", 32'(ldr_rvalid), 1);
        next_cycle();
        ldr_req = 0;
        settle();
        chk("b2b_rvalid1", 32'(ldr_rvalid), 1);
        next_cycle();
        settle();
        chk("b2b_rvalid_end", 32'(ldr_rvalid), 0);

        // Contention: loader forced on cycle 4, counter restarts, forced again on 9
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            if (c == 0) begin
                core_rd = 1; core_addr = 32'h10;
                ldr_req = 1; ldr_we = 0; ldr_addr = 32'h40;
            end
            if (c == 4 || c == 9) exp_q.push_back(32'h12345678);
            settle();
            chk($sformatf("cont_gnt_c%0d", c), 32'(ldr_gnt), (c == 4 || c == 9) ? 1 : 0);
            chk($sformatf("cont_stall_c%0d", c), 32'(core_stall), (c == 4 || c == 9) ? 1 : 0);
            chk($sformatf("cont_core_rdata_c%0d", c), core_rdata,
                (c == 4 || c == 9) ? 32'h0 : 32'hDEADBEEF);
            chk($sformatf("lim0_gnt_c%0d", c), 32'(ldr_gnt0), 1);
            chk($sformatf("lim0_stall_c%0d", c), 32'(core_stall0), 1);
            chk("lim0_mem_read", 32'(mem_read0), 1);
            chk("lim0_mem_write", 32'(mem_write0), 0);
            chk("lim0_mem_addr", mem_addr0, 32'h40);
            chk("lim0_mem_wdata", mem_wdata0, 32'h12345678);
            chk("lim0_core_rdata", core_rdata0, 0);
            if (c > 0) begin
                chk("lim0_rvalid", 32'(ldr_rvalid0), 1);
                chk("lim0_rdata", ldr_rdata0, 32'hC0FFEE00);
            end
        end
        next_cycle();
        ldr_req = 0;
        settle();
        chk("cont_core_after", 32'(core_stall), 0);
        chk("cont_core_rdata_after", core_rdata, 32'hDEADBEEF);

        // Same-address write conflict: loader forced, core retries last
        next_cycle();
        core_rd = 0; core_wr = 1; core_addr = 32'h80; core_wdata = 32'hAAAA0000;
        ldr_req = 1; ldr_we = 1; ldr_addr = 32'h80; ldr_wdata = 32'h5555FFFF;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) next_cycle();
            settle();
            chk($sformatf("conf_gnt_c%0d", c), 32'(ldr_gnt), (c == 4) ? 1 : 0);
            chk($sformatf("conf_wdata_c%0d", c), mem_wdata,
                (c == 4) ? 32'h5555FFFF : 32'hAAAA0000);
            chk($sformatf("conf_write_c%0d", c), 32'(mem_write), 1);
        end
        chk("conf_stall", 32'(core_stall), 1);
        next_cycle();
        ldr_req = 0;
        settle();
        chk("conf_retry_stall", 32'(core_stall), 0);
        chk("conf_retry_wdata", mem_wdata, 32'hAAAA0000);
        next_cycle();
        core_wr = 0; core_rd = 1; core_addr = 32'h80;
        settle();
        chk("conf_final_rd", core_rdata, 32'hAAAA0000);
        chk("conf_final_mem", mem[32], 32'hAAAA0000);

        // Reset right after a loader read grant
        next_cycle();
        core_rd = 0; ldr_req = 1; ldr_we = 0; ldr_addr = 32'h10;
        settle();
        chk("rmid_gnt", 32'(ldr_gnt), 1);
        next_cycle();
        reset = 0; core_wr = 1; core_addr = 32'h80; core_wdata = 32'h0;
        settle();
        chk("rmid_rvalid", 32'(ldr_rvalid), 0);
        chk("rmid_mem_write", 32'(mem_write), 0);
        chk("rmid_mem_read", 32'(mem_read), 0);
        chk("rmid_gnt_low", 32'(ldr_gnt), 0);
        chk("rmid_stall", 32'(core_stall), 0);
        next_cycle();
        settle();
        chk("rmid_rdata", ldr_rdata, 0);
        chk("rmid_starve_cnt", 32'(u_dut.u_starve.count), 0);
        chk("rmid_mem_kept", mem[32], 32'hAAAA0000);
        next_cycle();
        reset = 1; core_wr = 0; ldr_req = 0;
        settle();
        chk("sb_empty", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port data memory between the pipeline MEM stage and a loader/debug port used for program download and memory inspection. It sits between the MEM stage and the data memory. The core has priority. A saturating starvation counter guarantees the loader a slot, and the arbiter stalls the pipeline for that cycle. Loader reads return registered data one cycle after grant.

## Interface
- DATA_WIDTH, 32, data and address width
- STARVE_LIMIT, 4, maximum consecutive loader-denied cycles before the loader is forced a slot; 0 gives the loader absolute priority

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- core_mem_read_i  in  1  MEM-stage read request
- core_mem_write_i  in  1  MEM-stage write request
- core_addr_i  in  DATA_WIDTH  MEM-stage byte address
- core_wdata_i  in  DATA_WIDTH  MEM-stage write data
- core_rdata_o  out  DATA_WIDTH  read data to MEM stage (combinational)
- core_stall_o  out  1  MEM stage must hold; its access was not performed this cycle
- ldr_req_i  in  1  loader request; held with stable fields until granted
- ldr_we_i  in  1  1 = write, 0 = read
- ldr_addr_i  in  DATA_WIDTH  loader byte address
- ldr_wdata_i  in  DATA_WIDTH  loader write data
- ldr_gnt_o  out  1  loader access performed this cycle
- ldr_rvalid_o  out  1  ldr_rdata_o valid (one-cycle pulse)
- ldr_rdata_o  out  DATA_WIDTH  registered loader read data
- mem_write_o, mem_read_o  out  1  to data memory
- mem_addr_o, mem_wdata_o  out  DATA_WIDTH  to data memory
- mem_rdata_i  in  DATA_WIDTH  asynchronous read data from data memory

## Operation
- Define core_req = core_mem_read_i | core_mem_write_i.
- Loader is granted when ldr_req_i is high and either core_req is 0 or starve_cnt == STARVE_LIMIT. Otherwise the core is granted.
- The memory bus is muxed from the granted requester. If neither side requests, mem_read_o and mem_write_o are 0, and address/data follow the core inputs.
- core_stall_o = core_req & ldr_gnt_o.
- core_rdata_o = mem_rdata_i when the core is granted and core_mem_read_i is high. Otherwise it is 0.
- starve_cnt has width clog2(STARVE_LIMIT+1), minimum 1 bit. Next-state rules:
  - cleared when ldr_req_i = 0 or ldr_gnt_o = 1;
  - otherwise incremented, saturating at STARVE_LIMIT.
- Loader write commits at the edge that ends its grant cycle.
- Loader read: mem_rdata_i is captured into ldr_rdata_o at that same edge. ldr_rvalid_o is high for exactly the following cycle. ldr_rdata_o holds its value until the next loader read.
- Loader writes never raise ldr_rvalid_o.
- Addresses are passed through unmodified; word selection is the memory's job.
- Simultaneous core write and loader write to the same address: only the granted write occurs. The stalled core write retries next cycle.

## Timing
- While reset is low: all grants are 0, mem_write_o/mem_read_o = 0, core_stall_o = 0, core_rdata_o = 0.
- At the edge with reset low: starve_cnt = 0, ldr_rvalid_o = 0, ldr_rdata_o = 0.
- Reset asserted in the cycle after a loader read grant kills the pending rvalid pulse.
- ldr_gnt_o, core_stall_o, mem_* and core_rdata_o are combinational in the request cycle, with zero latency.
- Loader read latency: grant cycle + 1 to rvalid.
- Back-to-back loader grants are allowed. rvalid then stays high on consecutive cycles, with new data each cycle.
- Worst-case loader wait under continuous core traffic: STARVE_LIMIT denied cycles, then a grant. After a forced grant the counter restarts from 0.
- STARVE_LIMIT = 0: the loader wins every cycle it requests.

## Structure
- Shared package `dmem_arb_pkg`: grant encoding constants GNT_NONE, GNT_CORE and GNT_LDR (2 bits), plus the counter-width function.
- One natural sub-module: `dmem_starve_counter`, the saturating counter with clear, increment and at_limit.
- The remaining RTL is the combinational grant/mux logic and the loader read-data register.

## Test plan
- Core only: core read at 0x10 with memory word 0xDEADBEEF -> core_rdata_o = 0xDEADBEEF in the same cycle; core_stall_o = 0; ldr_gnt_o = 0.
- Loader only: write 0x12345678 to 0x40, then read 0x40 -> ldr_gnt_o high in each request cycle; ldr_rvalid_o pulses one cycle after the read grant with 0x12345678.
- Contention with STARVE_LIMIT = 4: core_req held high and loader requests at cycle 0 -> loader denied on cycles 0–3 and granted on cycle 4 with core_stall_o = 1; core granted on cycle 5.
- STARVE_LIMIT = 0 with both requesting -> loader granted every cycle; core_stall_o = 1 every cycle.
- Same-address conflict: core write 0xAAAA0000 and loader write 0x5555FFFF to 0x80, with the loader forced -> after two cycles memory holds 0xAAAA0000 (the core write retries last).
- Reset mid-operation: loader read granted, then reset low the next cycle -> ldr_rvalid_o = 0, starve_cnt = 0, ldr_rdata_o = 0; no memory write during reset.
